// File: rtl/gcd_controller.sv
// -----------------------------------------------------------------------------
// gcd_controller
//
// Control FSM for a 16-bit subtractive GCD datapath. It loads operand A and
// then operand B from the shared data_in bus. After that it performs one
// subtract-and-compare step per cycle until the datapath comparator reports
// A == B.
//
// A watchdog aborts a run that would never end (a zero operand) after
// MAX_ITER subtraction steps and raises err.
//
// Handshake with the system
//   start is sampled only in IDLE. It is a level, not an edge: a start held
//   high launches a new run every time IDLE is reached. busy is high while a
//   run is in progress (LOAD_A, LOAD_B, CMP). done is a one-cycle pulse, and
//   during that cycle the A register holds the GCD. err is raised when the
//   watchdog fires and stays high until the next accepted start.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           run request (sampled in IDLE only)
//   lt, gt, eq      datapath comparator flags (A<B, A>B, A==B)
//   ldA, ldB        load enables for the A and B registers
//   sel1, sel2      subtractor minuend / subtrahend select (1 = A, 0 = B)
//   sel_load        register input select (1 = data_in, 0 = subtractor)
//   op_sel          operand prompt for the data_in source (0 = A, 1 = B)
//   busy, done, err run status as described above
//   iter_cnt        subtraction steps taken in the current or last run
//   state_dbg       current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module gcd_controller #(
   parameter int MAX_ITER = 1023,
   parameter int ITER_W   = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              lt,
   input  logic              gt,
   input  logic              eq,
   output logic              ldA,
   output logic              ldB,
   output logic              sel1,
   output logic              sel2,
   output logic              sel_load,
   output logic              op_sel,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ITER_W-1:0] iter_cnt,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      CMP    = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } state_t;

   localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

   state_t            state_q, state_d;
   logic [ITER_W-1:0] cnt_q;
   logic              err_q;
   logic              cnt_clr;   // accepted start: clear counter and error
   logic              cnt_inc;   // a subtraction step happens this cycle
   logic              err_set;   // watchdog fires this cycle

   // State register, iteration counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (cnt_clr) begin
            cnt_q <= '0;
         end else if (cnt_inc) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (cnt_clr) begin
            err_q <= 1'b0;
         end else if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   // Next state and control decode.
   always_comb begin
      state_d  = state_q;
      ldA      = 1'b0;
      ldB      = 1'b0;
      sel1     = 1'b0;
      sel2     = 1'b0;
      sel_load = 1'b0;
      op_sel   = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      err_set  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD_A;
               cnt_clr = 1'b1;
            end
         end

         LOAD_A: begin
            busy     = 1'b1;
            ldA      = 1'b1;
            sel_load = 1'b1;
            op_sel   = 1'b0;
            state_d  = LOAD_B;
         end

         LOAD_B: begin
            busy     = 1'b1;
            ldB      = 1'b1;
            sel_load = 1'b1;
            op_sel   = 1'b1;
            state_d  = CMP;
         end

         CMP: begin
            busy = 1'b1;
            // No flag at all is illegal. It is treated like eq so that the
            // FSM can never get stuck on a broken comparator.
            if (eq || !(gt || lt)) begin
               state_d = DONE;
            end else if (cnt_q == MAX_CNT) begin
               state_d = ERR;
               err_set = 1'b1;
            end else if (gt) begin
               // A <- A - B
               ldA     = 1'b1;
               sel1    = 1'b1;
               sel2    = 1'b0;
               cnt_inc = 1'b1;
            end else begin
               // B <- B - A
               ldB     = 1'b1;
               sel1    = 1'b0;
               sel2    = 1'b1;
               cnt_inc = 1'b1;
            end
         end

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         ERR: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign err       = err_q;
   assign iter_cnt  = cnt_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_gcd_controller.sv
// -----------------------------------------------------------------------------
// tb_gcd_controller
//
// Drives gcd_controller together with a small behavioural 16-bit datapath.
// Results are compared against a reference GCD model that uses plain
// arithmetic.
// -----------------------------------------------------------------------------
module tb_gcd_controller;

   localparam int MAX_ITER = 16;
   localparam int ITER_W   = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic              start;
   logic              lt, gt, eq;
   logic              ldA, ldB, sel1, sel2, sel_load, op_sel;
   logic              busy, done, err;
   logic [ITER_W-1:0] iter_cnt;
   logic [2:0]        state_dbg;

   gcd_controller #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .lt        (lt),
      .gt        (gt),
      .eq        (eq),
      .ldA       (ldA),
      .ldB       (ldB),
      .sel1      (sel1),
      .sel2      (sel2),
      .sel_load  (sel_load),
      .op_sel    (op_sel),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .iter_cnt  (iter_cnt),
      .state_dbg (state_dbg)
   );

   // ---------------- behavioural datapath ----------------
   logic [15:0] a_reg, b_reg, op_a, op_b, data_in, diff;
   logic        force_none;   // blanks all comparator flags (illegal case)

   assign data_in = op_sel ? op_b : op_a;
   assign diff    = (sel1 ? a_reg : b_reg) - (sel2 ? a_reg : b_reg);
   assign eq      = !force_none && (a_reg == b_reg);
   assign gt      = !force_none && (a_reg >  b_reg);
   assign lt      = !force_none && (a_reg <  b_reg);

   always_ff @(posedge clk) begin
      if (ldA) a_reg <= sel_load ? data_in : diff;
      if (ldB) b_reg <= sel_load ? data_in : diff;
   end

   // ---------------- scoreboard ----------------
   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   logic [0:0] exp_q[$];   // expected subtract pattern: 1 = A-step, 0 = B-step
   logic [0:0] got_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: subtractive GCD with a step cap.
   task automatic ref_model(input logic [15:0] a_in, input logic [15:0] b_in,
                            output int n, output logic [15:0] a_fin, output bit e);
      logic [15:0] a, b;
      bit fin;
      a = a_in; b = b_in; n = 0; e = 0; fin = 0;
      exp_q.delete();
      while (!fin) begin
         if (force_none || a == b) begin
            fin = 1;
         end else if (n == MAX_ITER) begin
            e = 1; fin = 1;
         end else begin
            if (a > b) begin a = a - b; exp_q.push_back(1'b1); end
            else       begin b = b - a; exp_q.push_back(1'b0); end
            n++;
         end
      end
      a_fin = a;
   endtask

   // Vector {ldA, ldB, sel_load, op_sel, busy, err}.
   function automatic logic [5:0] ctl_vec();
      return {ldA, ldB, sel_load, op_sel, busy, err};
   endfunction

   // Waits, within a bounded number of cycles, for done or err.
   // Counts cycles from the current one.
   task automatic wait_end(inout int cyc, output bit seen);
      seen = 0;
      while (!seen && cyc <= MAX_ITER + 10) begin
         if (cyc >= 3 && busy && (ldA || ldB)) got_q.push_back(ldA);
         if (done || err) seen = 1;
         else begin @(posedge clk); #1; cyc++; end
      end
   endtask

   // One complete run. pulse_at gives a cycle at which start is pulsed during
   // the run (0 = none). hold keeps start high through done.
   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input int pulse_at, input bit hold);
      int n, cyc, cyc2;
      logic [15:0] g;
      bit e, seen;
      ref_model(a, b, n, g, e);
      op_a = a; op_b = b;
      got_q.delete();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      cyc = 1;
      check({name, "_load_a"}, ctl_vec(), 6'b101010);
      @(posedge clk); #1; cyc++;
      check({name, "_load_b"}, ctl_vec(), 6'b011110);
      @(posedge clk); #1; cyc++;
      if (pulse_at != 0) begin
         while (cyc < pulse_at) begin
            if (busy && (ldA || ldB)) got_q.push_back(ldA);
            @(posedge clk); #1; cyc++;
         end
         start = 1'b1;
         if (busy && (ldA || ldB)) got_q.push_back(ldA);
         @(posedge clk); #1; cyc++;
         start = 1'b0;
      end
      wait_end(cyc, seen);
      check({name, "_end_seen"}, 32'(seen), 32'd1);
      check({name, "_end_cycle"}, 32'(cyc), 32'(n + 4));
      check({name, "_done"}, 32'(done), 32'(!e));
      check({name, "_err"}, 32'(err), 32'(e));
      check({name, "_iter_cnt"}, 32'(iter_cnt), 32'(n));
      check({name, "_a_final"}, 32'(a_reg), 32'(g));
      check({name, "_pattern_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      if (got_q.size() == exp_q.size()) begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) check({name, "_pattern"}, 32'(got_q[i]), 32'(exp_q[i]));
         end
      end
      // Cycle after done/ERR: back in IDLE, err held if aborted, no done.
      @(posedge clk); #1;
      check({name, "_idle_busy_done"}, {30'd0, busy, done}, 32'd0);
      check({name, "_err_hold"}, 32'(err), 32'(e));
      check({name, "_iter_hold"}, 32'(iter_cnt), 32'(n));
      if (hold) begin
         @(posedge clk); #1;
         check({name, "_relaunch_a"}, ctl_vec(), 6'b101010);
         start = 1'b0;
         @(posedge clk); #1;
         check({name, "_relaunch_b"}, ctl_vec(), 6'b011110);
         cyc2 = 3;
         got_q.delete();
         @(posedge clk); #1;
         wait_end(cyc2, seen);
         check({name, "_rerun_cycle"}, 32'(cyc2), 32'(n + 4));
         check({name, "_rerun_a"}, 32'(a_reg), 32'(g));
         @(posedge clk); #1;
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int cyc;
      bit seen;
      rst = 1'b1; start = 1'b0; force_none = 1'b0; op_a = '0; op_b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("reset_outputs",
               {ldA, ldB, sel1, sel2, sel_load, op_sel, busy, done, err}, 9'd0);
         check("reset_iter_cnt", 32'(iter_cnt), 32'd0);
      end

      run_op("gcd_48_18", 16'd48, 16'd18, 0, 0);
      run_op("gcd_7_7",   16'd7,  16'd7,  0, 0);
      run_op("zero_b",    16'd5,  16'd0,  0, 0);
      run_op("after_err", 16'd9,  16'd6,  0, 0);   // err must clear on start
      run_op("busy_pulse", 16'd48, 16'd18, 4, 0);  // start ignored mid-run
      run_op("hold_start", 16'd15, 16'd10, 0, 1);

      force_none = 1'b1;
      run_op("no_flags", 16'd9, 16'd4, 0, 0);
      force_none = 1'b0;

      // Reset in the middle of a long run.
      op_a = 16'd1000; op_b = 16'd3;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("pre_reset_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_reset_outputs",
            {ldA, ldB, sel1, sel2, sel_load, op_sel, busy, done, err}, 9'd0);
      check("mid_reset_iter_cnt", 32'(iter_cnt), 32'd0);
      run_op("post_reset", 16'd12, 16'd8, 0, 0);

      for (int i = 0; i < 10; i++) begin
         run_op("random", 16'($urandom_range(0, 60)), 16'($urandom_range(1, 60)), 0, 0);
      end

      // start held low: stays idle.
      cyc = 1;
      repeat (3) @(posedge clk);
      #1;
      seen = busy;
      check("idle_stays", 32'(seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- Control FSM for the 16-bit subtractive GCD datapath.
- Sequences operand loading from the shared data_in bus, then runs one subtract-and-compare step per cycle until the comparator reports equal.
- Provides a start/busy/done handshake to the system, plus a watchdog that aborts non-terminating runs (zero operand) with an error flag.
- Drives ldA, ldB, sel1, sel2 and sel_load; consumes lt, gt and eq.

Parameters:
- MAX_ITER, 1023: maximum subtraction steps before abort; must be ≥1.
- ITER_W, 10: width of the iteration counter; must satisfy 2^ITER_W-1 ≥ MAX_ITER.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- lt  input  1  datapath comparator: A < B.
- gt  input  1  datapath comparator: A > B.
- eq  input  1  datapath comparator: A == B.
- ldA  output  1  load enable, A register.
- ldB  output  1  load enable, B register.
- sel1  output  1  subtractor minuend mux: 1 = A, 0 = B.
- sel2  output  1  subtractor subtrahend mux: 1 = A, 0 = B.
- sel_load  output  1  register bus mux: 1 = data_in, 0 = subtractor output.
- op_sel  output  1  operand prompt to the source driving data_in: 0 = present A, 1 = present B.
- busy  output  1  high in LOAD_A, LOAD_B and CMP.
- done  output  1  one-cycle pulse; the GCD is valid in the A register (equal to B) during this cycle.
- err  output  1  watchdog abort; sticky until the next accepted start or reset.
- iter_cnt  output  ITER_W  subtraction steps taken in the current or last run.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-run):
  - state goes to IDLE; iter_cnt=0; err=0.
  - all outputs 0 in the following cycle; datapath registers are not touched.
- States: IDLE, LOAD_A, LOAD_B, CMP, DONE, ERR.
- Control outputs are decoded from state, and in CMP also from the comparator flags. Default value of every control output is 0.
- IDLE:
  - all control outputs 0.
  - start=1 → LOAD_A; at the same edge clear iter_cnt and err.
- LOAD_A: ldA=1, sel_load=1, op_sel=0; data_in must hold operand A this cycle → LOAD_B.
- LOAD_B: ldB=1, sel_load=1, op_sel=1; data_in must hold operand B → CMP.
- CMP, evaluated each cycle, priority eq > gt > lt:
  - eq=1 → DONE; no load.
  - gt=1 and iter_cnt<MAX_ITER: ldA=1, sel1=1, sel2=0, sel_load=0 (A←A−B); iter_cnt+1; stay in CMP.
  - lt=1 and iter_cnt<MAX_ITER: ldB=1, sel1=0, sel2=1, sel_load=0 (B←B−A); iter_cnt+1; stay in CMP.
  - not eq and iter_cnt==MAX_ITER: no load → ERR.
  - no flag asserted (illegal): treated as eq → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- ERR: err=1 for one cycle → IDLE; err stays high in IDLE until the next accepted start.
- start is ignored outside IDLE; a start held high continuously re-launches a new run every time IDLE is reached.
- Latency: with N subtractions, done is high during cycle N+4 after the edge that sampled start.
  - start edge E0; loads at E1 and E2; subtractions at E3..E(2+N); eq seen at E(3+N).
- iter_cnt never wraps: it is capped by MAX_ITER and holds its value after DONE/ERR until the next start.

Test Plan:
- Reset, then idle 3 cycles → all outputs 0, iter_cnt=0.
- start, A=48, B=18 → subtract pattern A, A, B, A; done pulses 8 cycles after the start edge; A=6 at done; iter_cnt=4; err=0.
- start, A=7, B=7 → no loads in CMP; done 4 cycles after start; iter_cnt=0; A=7.
- MAX_ITER=16, A=5, B=0 → 16 A-loads with A unchanged at 5; ERR; err=1 held in IDLE; next start clears err.
- Assert rst in CMP during A=1000, B=3 → next cycle IDLE, busy=0, iter_cnt=0; a new start (A=12, B=8) gives done with A=4.
- Pulse start while busy → ignored, result unchanged. Hold start high across DONE → second run begins in the cycle after the done pulse, with op_sel sequence 0 then 1.
